morse_key_timer: RTL and testbench

//   Upstream stage of the Morse-to-UART path. Times a debounced key level and emits
//   one-cycle pulses: dot, dash, letter gap (lg), word gap (wg).

---
 rtl/morse_key_timer.sv | 181 ++++++++++++++++++
 tb/tb_morse_key_timer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_key_timer.sv
// ============================================================================
// morse_key_timer
// ----------------------------------------------------------------------------
// Purpose
//   First stage of the Morse-to-UART path. It measures how long a debounced
//   key is held and released, in Morse time units, and turns those durations
//   into one-cycle classification pulses:
//     dot  - a press shorter than DASH_MIN units has just ended
//     dash - a press of DASH_MIN units or more has just ended
//     lg   - the key has stayed released for LG_MIN units after a symbol
//     wg   - the key has stayed released for WG_MIN units after a symbol
//   Downstream logic (symbol shift register, symbol counter, ROM/UART write
//   enable) consumes these pulses. Nothing is stored here beyond timing.
//
// Ports
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   b      in   debounced key level, 1 = pressed
//   dot    out  one-cycle pulse, short press completed
//   dash   out  one-cycle pulse, long press completed
//   lg     out  one-cycle pulse, letter gap elapsed
//   wg     out  one-cycle pulse, word gap elapsed
//   busy   out  level, high whenever the FSM is not idle
//
// Handshake
//   There is no valid/ready pairing: b is a free-running level sampled on
//   every rising clk edge, and each pulse output is a registered, single-cycle
//   strobe that the consumer must accept in the cycle it is high. At most one
//   of dot/dash/lg/wg is high in any cycle.
// ============================================================================
module morse_key_timer #(
    parameter int UNIT_CYCLES = 5_000_000,
    parameter int DASH_MIN    = 2,
    parameter int LG_MIN      = 2,
    parameter int WG_MIN      = 6,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic b,
    output logic dot,
    output logic dash,
    output logic lg,
    output logic wg,
    output logic busy
);

    // Prescaler width; UNIT_CYCLES >= 2 keeps this at least one bit.
    localparam int PW = $clog2(UNIT_CYCLES);

    localparam logic [PW-1:0]    PRE_LAST  = PW'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] UNITS_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DASH_U    = CNT_W'(DASH_MIN);
    localparam logic [CNT_W-1:0] LG_U      = CNT_W'(LG_MIN);
    localparam logic [CNT_W-1:0] WG_U      = CNT_W'(WG_MIN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2,
        LGAP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [PW-1:0]     prescaler;
    logic [PW-1:0]     prescaler_next;
    logic [CNT_W-1:0]  units;
    logic [CNT_W-1:0]  units_next;

    logic              dot_next;
    logic              dash_next;
    logic              lg_next;
    logic              wg_next;

    // Timebase helpers: what the counters become on this edge if nothing
    // clears them.
    logic              tick;
    logic [PW-1:0]     prescaler_inc;
    logic [CNT_W-1:0]  units_inc;

    assign tick          = (prescaler == PRE_LAST);
    assign prescaler_inc = tick ? '0 : prescaler + PW'(1);
    // Saturate so a very long press still reads as "many units" rather than
    // wrapping back into dot territory.
    assign units_inc     = (tick && (units != UNITS_MAX)) ? units + CNT_W'(1) : units;

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            prescaler <= '0;
            units     <= '0;
            dot       <= 1'b0;
            dash      <= 1'b0;
            lg        <= 1'b0;
            wg        <= 1'b0;
        end else begin
            state     <= state_next;
            prescaler <= prescaler_next;
            units     <= units_next;
            dot       <= dot_next;
            dash      <= dash_next;
            lg        <= lg_next;
            wg        <= wg_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        prescaler_next = prescaler_inc;
        units_next     = units_inc;
        dot_next       = 1'b0;
        dash_next      = 1'b0;
        lg_next        = 1'b0;
        wg_next        = 1'b0;

        unique case (state)
            IDLE: begin
                if (b) begin
                    state_next     = PRESS;
                    prescaler_next = '0;
                    units_next     = '0;
                end
            end

            PRESS: begin
                if (!b) begin
                    state_next     = GAP;
                    prescaler_next = '0;
                    units_next     = '0;
                    // Classify on the count including this edge's tick, so a
                    // press of exactly DASH_MIN whole units is already a dash.
                    if (units_inc >= DASH_U) begin
                        dash_next = 1'b1;
                    end else begin
                        dot_next  = 1'b1;
                    end
                end
            end

            GAP: begin
                // A press always wins over a threshold landing on the same edge.
                if (b) begin
                    state_next     = PRESS;
                    prescaler_next = '0;
                    units_next     = '0;
                end else if (tick && (units_inc == LG_U)) begin
                    state_next = LGAP;
                    lg_next    = 1'b1;
                end
            end

            LGAP: begin
                // Units keep running from the gap start so the word gap is
                // measured from the end of the symbol, not from the lg pulse.
                if (b) begin
                    state_next     = PRESS;
                    prescaler_next = '0;
                    units_next     = '0;
                end else if (tick && (units_inc == WG_U)) begin
                    state_next = IDLE;
                    wg_next    = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_morse_key_timer.sv
// ============================================================================
// tb_morse_key_timer
// ----------------------------------------------------------------------------
// Directed scenarios followed by a randomized key stream, all compared cycle
// by cycle against a duration-based reference model (press length and gap
// length counted in clock cycles, classified with plain division).
// ============================================================================
module tb_morse_key_timer;

  localparam int UNIT     = 10;
  localparam int DASH_MIN = 2;
  localparam int LG_MIN   = 2;
  localparam int WG_MIN   = 6;
  localparam int CNT_W    = 4;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk;
  logic reset;
  logic b;
  logic dot;
  logic dash;
  logic lg;
  logic wg;
  logic busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  morse_key_timer #(
    .UNIT_CYCLES (UNIT),
    .DASH_MIN    (DASH_MIN),
    .LG_MIN      (LG_MIN),
    .WG_MIN      (WG_MIN),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .b     (b),
    .dot   (dot),
    .dash  (dash),
    .lg    (lg),
    .wg    (wg),
    .busy  (busy)
  );

  // --------------------------------------------------------------------------
  // Bookkeeping
  // --------------------------------------------------------------------------
  int n_checks;
  int n_pass;
  int n_fail;
  int cyc;

  int cnt_dot;
  int cnt_dash;
  int cnt_lg;
  int cnt_wg;
  int last_dot_cyc;
  int last_dash_cyc;
  int last_lg_cyc;
  int last_wg_cyc;
  bit saw_lg_since_symbol;

  // Reference model: durations, not states.
  bit m_pressing;
  bit m_in_gap;
  int m_press_len;
  int m_gap_len;

  // Expected {dot, dash, lg, wg, busy} per clock edge.
  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step(input logic bv, input logic rv);
    logic [4:0] e;
    e = '0;
    if (rv) begin
      m_pressing = 0;
      m_in_gap   = 0;
    end else if (m_pressing) begin
      m_press_len++;
      if (!bv) begin
        if ((m_press_len / UNIT) >= DASH_MIN) e[3] = 1'b1;
        else                                  e[4] = 1'b1;
        m_pressing = 0;
        m_in_gap   = 1;
        m_gap_len  = 0;
      end
    end else if (m_in_gap) begin
      m_gap_len++;
      if (bv) begin
        m_in_gap    = 0;
        m_pressing  = 1;
        m_press_len = 0;
      end else if (m_gap_len == LG_MIN * UNIT) begin
        e[2] = 1'b1;
      end else if (m_gap_len == WG_MIN * UNIT) begin
        e[1]     = 1'b1;
        m_in_gap = 0;
      end
    end else if (bv) begin
      m_pressing  = 1;
      m_press_len = 0;
    end
    e[0] = m_pressing || m_in_gap;
    exp_q.push_back(e);
  endtask

  // --------------------------------------------------------------------------
  // Driver: one clock edge with the given key level and reset
  // --------------------------------------------------------------------------
  task automatic step(input logic bv, input logic rv);
    logic [4:0] e;
    @(negedge clk);
    b     = bv;
    reset = rv;
    model_step(bv, rv);
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    check("outputs", {27'd0, dot, dash, lg, wg, busy}, {27'd0, e});
    check("onehot", {31'd0, ($countones({dot, dash, lg, wg}) <= 1)}, 32'd1);
    if (dot)  begin cnt_dot++;  last_dot_cyc  = cyc; saw_lg_since_symbol = 0; end
    if (dash) begin cnt_dash++; last_dash_cyc = cyc; saw_lg_since_symbol = 0; end
    if (lg)   begin cnt_lg++;   last_lg_cyc   = cyc; saw_lg_since_symbol = 1; end
    if (wg) begin
      cnt_wg++;
      last_wg_cyc = cyc;
      check("wg_after_lg", {31'd0, saw_lg_since_symbol}, 32'd1);
    end
  endtask

  task automatic press(input int n);
    repeat (n) step(1'b1, 1'b0);
  endtask

  task automatic release_key(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    cnt_dot  = 0;
    cnt_dash = 0;
    cnt_lg   = 0;
    cnt_wg   = 0;
  endtask

  // --------------------------------------------------------------------------
  // Directed + random sequence
  // --------------------------------------------------------------------------
  initial begin
    int plen;
    int glen;
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    cyc      = 0;
    m_pressing  = 0;
    m_in_gap    = 0;
    m_press_len = 0;
    m_gap_len   = 0;
    saw_lg_since_symbol = 0;
    last_dot_cyc = 0; last_dash_cyc = 0; last_lg_cyc = 0; last_wg_cyc = 0;
    b     = 1'b0;
    reset = 1'b1;

    // Reset state
    repeat (3) step(1'b0, 1'b1);
    check("reset_pulses", {28'd0, dot, dash, lg, wg}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    release_key(2);
    clear_counts();

    // 1: 12-cycle press -> dot, lg 20 later, wg 40 after that
    press(12);
    release_key(1);
    check("t1_dot", cnt_dot, 1);
    check("t1_no_dash", cnt_dash, 0);
    release_key(20);
    check("t1_lg", cnt_lg, 1);
    check("t1_lg_latency", last_lg_cyc - last_dot_cyc, LG_MIN * UNIT);
    release_key(40);
    check("t1_wg", cnt_wg, 1);
    check("t1_wg_latency", last_wg_cyc - last_dot_cyc, WG_MIN * UNIT);
    release_key(3);
    check("t1_idle", {31'd0, busy}, 32'd0);

    // 2: 35-cycle press and saturating 400-cycle press, both dashes
    clear_counts();
    press(35);
    release_key(1);
    check("t2_dash35", cnt_dash, 1);
    release_key(65);
    press(400);
    release_key(1);
    check("t2_dash400", cnt_dash, 2);
    check("t2_no_dot", cnt_dot, 0);
    release_key(65);

    // Boundary: press of exactly DASH_MIN units is a dash, one less is a dot
    clear_counts();
    press(20);
    release_key(1);
    check("bnd_dash20", cnt_dash, 1);
    release_key(5);
    press(19);
    release_key(1);
    check("bnd_dot19", cnt_dot, 1);
    release_key(65);

    // 3: dot, 15-cycle gap, dash -> no lg in between
    clear_counts();
    press(12);
    release_key(15);
    press(35);
    release_key(1);
    check("t3_dot", cnt_dot, 1);
    check("t3_dash", cnt_dash, 1);
    check("t3_no_lg", cnt_lg, 0);
    release_key(20);
    check("t3_lg_latency", last_lg_cyc - last_dash_cyc, LG_MIN * UNIT);
    release_key(45);

    // 4: dot, lg, press at gap cycle 45 -> no wg, next symbol normal
    clear_counts();
    press(12);
    release_key(45);
    press(12);
    release_key(1);
    check("t4_lg", cnt_lg, 1);
    check("t4_no_wg", cnt_wg, 0);
    check("t4_dot2", cnt_dot, 2);
    release_key(61);
    check("t4_wg", cnt_wg, 1);

    // 5: reset mid-press aborts silently
    clear_counts();
    press(25);
    step(1'b1, 1'b1);
    check("t5_reset_busy", {31'd0, busy}, 32'd0);
    release_key(30);
    check("t5_no_pulse", cnt_dot + cnt_dash + cnt_lg + cnt_wg, 0);
    press(12);
    release_key(1);
    check("t5_dot", cnt_dot, 1);
    release_key(65);

    // 6: random key stream, ~10k cycles
    clear_counts();
    while (cyc < 11000) begin
      plen = $urandom_range(1, 45);
      glen = ($urandom_range(0, 3) == 0) ? $urandom_range(50, 80) : $urandom_range(1, 30);
      press(plen);
      release_key(glen);
      if ($urandom_range(0, 99) == 0) step($urandom_range(0, 1) == 1, 1'b1);
    end
    release_key(70);
    check("t6_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
